// File: rtl/seqdet_pkg.sv
// ============================================================================
//  Module      : seqdet_pkg
//  Description : Shared defaults and helpers for the match event logger.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seqdet_pkg;

    localparam int TS_WIDTH_DEF  = 16;
    localparam int DEPTH_DEF     = 8;
    localparam int CNT_WIDTH_DEF = 16;

    // One-bit step for a saturating counter: increment only if requested
    // and the counter is not already all-ones.
    function automatic logic sat_step(input logic inc, input logic at_max);
        return inc & ~at_max;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
//  Module      : sync_fifo
//  Description : Synchronous first-word-fall-through FIFO with a registered
//                head entry and occupancy-derived full/empty.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_LW-1:0]  r_level;
    logic [WIDTH-1:0] r_head;

    logic             w_do_rd;
    logic             w_do_wr;
    logic [c_AW-1:0]  w_rd_next;

    assign empty     = (r_level == '0);
    assign full      = (r_level == c_LW'(DEPTH));
    // A read only happens when there is something to read; a write into a
    // full FIFO is allowed only when a read frees the slot in the same cycle.
    assign w_do_rd   = rd_en & ~empty;
    assign w_do_wr   = wr_en & (~full | w_do_rd);
    assign w_rd_next = r_rd_ptr + c_AW'(1);

    assign rd_data   = r_head;
    assign level     = r_level;

    // Storage array; contents need no reset because occupancy gates validity.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the registered head copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_head   <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= w_rd_next;
            end

            case ({w_do_wr, w_do_rd})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase

            // Head follows the next stored entry after a read, or takes the
            // incoming word directly when it becomes the only entry.
            if (w_do_rd) begin
                if (r_level > c_LW'(1)) begin
                    r_head <= r_mem[w_rd_next];
                end else if (w_do_wr) begin
                    r_head <= wr_data;
                end
            end else if (w_do_wr && empty) begin
                r_head <= wr_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/match_event_logger.sv
// ============================================================================
//  Module      : match_event_logger
//  Description : Timestamps each detector match, buffers it in a FWFT FIFO
//                drained by valid/ready, and keeps match/drop statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module match_event_logger
    import seqdet_pkg::*;
#(
    parameter int TS_WIDTH  = TS_WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     detected,
    input  logic                     evt_ready,
    output logic                     evt_valid,
    output logic [TS_WIDTH-1:0]      evt_ts,
    output logic [CNT_WIDTH-1:0]     match_count,
    output logic [CNT_WIDTH-1:0]     drop_count,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    logic [TS_WIDTH-1:0]  r_ts;
    logic [CNT_WIDTH-1:0] r_match_count;
    logic [CNT_WIDTH-1:0] r_drop_count;
    logic                 r_overflow;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_drop;

    assign evt_valid   = ~w_empty;
    assign w_pop       = evt_ready & ~w_empty;
    // An event is lost only when the FIFO is full and no pop makes room.
    assign w_drop      = detected & w_full & ~w_pop;

    assign match_count = r_match_count;
    assign drop_count  = r_drop_count;
    assign overflow    = r_overflow;

    sync_fifo #(
        .WIDTH (TS_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (detected),
        .wr_data (r_ts),
        .rd_en   (evt_ready),
        .rd_data (evt_ts),
        .full    (w_full),
        .empty   (w_empty),
        .level   (level)
    );

    // Free-running timestamp, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_WIDTH'(1);
        end
    end

    // Saturating match/drop counters and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_match_count <= '0;
            r_drop_count  <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_match_count <= r_match_count
                           + CNT_WIDTH'(sat_step(detected, &r_match_count));
            r_drop_count  <= r_drop_count
                           + CNT_WIDTH'(sat_step(w_drop, &r_drop_count));
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_match_event_logger.sv
// ============================================================================
//  Module      : tb_match_event_logger
//  Description : Directed self-checking bench for match_event_logger.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_match_event_logger;

    localparam int c_TSW = 4;
    localparam int c_DEP = 8;
    localparam int c_CW  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              detected;
    logic              evt_ready;
    logic              evt_valid;
    logic [c_TSW-1:0]  evt_ts;
    logic [c_CW-1:0]   match_count;
    logic [c_CW-1:0]   drop_count;
    logic              overflow;
    logic [3:0]        level;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference timestamp: zero in the cycle after a reset edge, +1 per cycle.
    logic [c_TSW-1:0]  r_ref_ts;

    match_event_logger #(
        .TS_WIDTH  (c_TSW),
        .DEPTH     (c_DEP),
        .CNT_WIDTH (c_CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .detected    (detected),
        .evt_ready   (evt_ready),
        .evt_valid   (evt_valid),
        .evt_ts      (evt_ts),
        .match_count (match_count),
        .drop_count  (drop_count),
        .overflow    (overflow),
        .level       (level)
    );

    always #5 clk = ~clk;

    // Reference timestamp model.
    always @(posedge clk) begin
        if (reset) r_ref_ts <= '0;
        else       r_ref_ts <= r_ref_ts + 4'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        detected = 1'b0;
        evt_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_ts(input logic [c_TSW-1:0] v);
        int n = 0;
        while (r_ref_ts != v && n < 40) begin
            tick();
            n++;
        end
        if (r_ref_ts != v) check("wait_ts_timeout", 32'(r_ref_ts), 32'(v));
    endtask

    initial begin
        logic [c_TSW-1:0] s;
        logic [c_TSW-1:0] t;
        logic [c_TSW-1:0] prev;

        reset = 1'b1;
        detected = 1'b0;
        evt_ready = 1'b0;
        tick();              // cycle 0
        tick();              // cycle 1
        reset = 1'b0;        // now in cycle 2, ts = 0

        // Reset state
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_ts", 32'(evt_ts), 0);
        check("rst_match", 32'(match_count), 0);
        check("rst_drop", 32'(drop_count), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_level", 32'(level), 0);

        // Single event in cycle 5 (ts = 3)
        tick(); tick(); tick();
        detected = 1'b1;
        tick();
        detected = 1'b0;
        check("single_valid", 32'(evt_valid), 1);
        check("single_ts", 32'(evt_ts), 3);
        check("single_match", 32'(match_count), 1);
        check("single_level", 32'(level), 1);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("single_popped", 32'(evt_valid), 0);
        check("single_level0", 32'(level), 0);

        // Overlapping matches at ts 10, 11, 12 with consumer always ready
        do_reset();
        wait_ts(4'd10);
        detected = 1'b1;
        evt_ready = 1'b1;
        tick();
        check("ovl_valid", 32'(evt_valid), 1);
        check("ovl_ts0", 32'(evt_ts), 10);
        tick();
        check("ovl_ts1", 32'(evt_ts), 11);
        tick();
        detected = 1'b0;
        check("ovl_ts2", 32'(evt_ts), 12);
        check("ovl_match", 32'(match_count), 3);
        tick();
        evt_ready = 1'b0;
        check("ovl_empty", 32'(evt_valid), 0);

        // Overflow: 10 detections, no consumer
        do_reset();
        s = r_ref_ts;
        detected = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        detected = 1'b0;
        check("of_level", 32'(level), 8);
        check("of_drop", 32'(drop_count), 2);
        check("of_ovf", 32'(overflow), 1);
        check("of_match", 32'(match_count), 10);
        evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("of_drain_valid", 32'(evt_valid), 1);
            check("of_drain_ts", 32'(evt_ts), 32'(4'(s + 4'(i))));
            tick();
        end
        evt_ready = 1'b0;
        check("of_drained", 32'(evt_valid), 0);
        check("of_ovf_sticky", 32'(overflow), 1);

        // Full FIFO with simultaneous push and pop
        do_reset();
        s = r_ref_ts;
        detected = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("fpp_full", 32'(level), 8);
        evt_ready = 1'b1;
        t = r_ref_ts;
        tick();
        detected = 1'b0;
        evt_ready = 1'b0;
        check("fpp_level", 32'(level), 8);
        check("fpp_drop", 32'(drop_count), 0);
        check("fpp_ovf", 32'(overflow), 0);
        evt_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check("fpp_drain_ts", 32'(evt_ts), 32'(4'(s + 4'(i + 1))));
            tick();
        end
        check("fpp_last_ts", 32'(evt_ts), 32'(t));
        tick();
        evt_ready = 1'b0;
        check("fpp_empty", 32'(evt_valid), 0);

        // Timestamp wrap 15 -> 0
        do_reset();
        wait_ts(4'd15);
        detected = 1'b1;
        tick();
        tick();
        detected = 1'b0;
        evt_ready = 1'b1;
        check("wrap_ts15", 32'(evt_ts), 15);
        tick();
        check("wrap_ts0", 32'(evt_ts), 0);
        tick();
        check("wrap_empty", 32'(evt_valid), 0);

        // Twenty push/pop pairs crossing the pointer wrap
        detected = 1'b1;
        for (int i = 0; i < 20; i++) begin
            prev = r_ref_ts;
            tick();
            check("pp_valid", 32'(evt_valid), 1);
            check("pp_ts", 32'(evt_ts), 32'(prev));
            check("pp_level", 32'(level), 1);
        end
        detected = 1'b0;
        tick();
        evt_ready = 1'b0;
        check("pp_empty", 32'(evt_valid), 0);

        // Mid-operation reset with 5 buffered entries and overflow set
        do_reset();
        detected = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        detected = 1'b0;
        evt_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        evt_ready = 1'b0;
        check("mr_level5", 32'(level), 5);
        check("mr_ovf_pre", 32'(overflow), 1);
        reset = 1'b1;
        detected = 1'b1;     // ignored during reset
        tick();
        reset = 1'b0;
        check("mr_valid", 32'(evt_valid), 0);
        check("mr_ts", 32'(evt_ts), 0);
        check("mr_match", 32'(match_count), 0);
        check("mr_drop", 32'(drop_count), 0);
        check("mr_ovf", 32'(overflow), 0);
        check("mr_level", 32'(level), 0);
        tick();              // detected still high: logs ts = 0
        detected = 1'b0;
        check("mr_restart_ts", 32'(evt_ts), 0);
        check("mr_restart_match", 32'(match_count), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
